systolic_wave_ctrl: RTL

Parametrised successor to the single-shot valid pipeline controller that feeds the MAC array's `valid_in_0` lane. It streams a burst of `num_vecs` input vectors into an `N_COLS`-column systolic array and generates a staggered per-column valid wave with programmable skew. It also provides upstream back-pressure (`hold`), an upstream fetch strobe (`a_ready`), and an optional per-column accumulator-clear wave. It sits between the activation source and `mac_array`, replacing the fixed 4-column controller.

---
 rtl/systolic_wave_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/systolic_wave_ctrl.sv
// Burst valid-wave controller for an N_COLS-column systolic MAC array.
// Optional per-column accumulator-clear wave is enabled by WAVE_CLEAR_EN.
module systolic_wave_ctrl #(
  parameter int N_COLS  = 4,
  parameter int SKEW    = 1,
  parameter int DEPTH_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DEPTH_W-1:0] num_vecs,
  input  logic               hold,
  output logic               a_ready,
  output logic [N_COLS-1:0]  valid_ctrl,
  output logic [N_COLS-1:0]  clear_ctrl,
  output logic               busy,
  output logic               done
);

  localparam int D  = (N_COLS - 1) * SKEW + 1;
  localparam int CW = $clog2((N_COLS - 1) * SKEW + 2);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]         state;
  logic [DEPTH_W-1:0] remaining;
  logic [CW-1:0]      drain_cnt;
  logic [D-1:0]       wave;
  logic               issue;
  logic               last_issue;
  logic               drain_end;

  assign issue      = (state == S_LOAD) && !hold;
  assign last_issue = issue && (remaining == DEPTH_W'(1));
  assign drain_end  = (drain_cnt == CW'(D - 1));

  assign a_ready = issue;
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      remaining <= '0;
      drain_cnt <= '0;
    end else begin
      unique case (1'b1)
        state == S_IDLE: begin
          drain_cnt <= '0;
          if (start) begin
            remaining <= num_vecs;
            state     <= (num_vecs == '0) ? S_DONE : S_LOAD;
          end
        end
        state == S_LOAD: begin
          if (issue) begin
            remaining <= remaining - DEPTH_W'(1);
            if (last_issue) state <= S_DRAIN;
          end
        end
        state == S_DRAIN: begin
          if (drain_end) begin
            state     <= S_DONE;
            drain_cnt <= '0;
          end else begin
            drain_cnt <= drain_cnt + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // The wave advances every cycle so hold bubbles travel down the columns.
  always_ff @(posedge clk) begin
    if (rst) wave <= '0;
    else     wave <= D'({wave, issue});
  end

  for (genvar k = 0; k < N_COLS; k++) begin : g_valid
    assign valid_ctrl[k] = wave[k*SKEW];
  end

`ifdef WAVE_CLEAR_EN
  logic         first;
  logic [D-1:0] cwave;

  // first marks the next issue as the opening vector of the burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      first <= 1'b0;
      cwave <= '0;
    end else begin
      if (state == S_IDLE && start) first <= 1'b1;
      else if (issue)               first <= 1'b0;
      cwave <= D'({cwave, issue & first});
    end
  end

  for (genvar k = 0; k < N_COLS; k++) begin : g_clear
    assign clear_ctrl[k] = cwave[k*SKEW];
  end
`else
  assign clear_ctrl = '0;
`endif

endmodule
